// File: rtl/regfile_sb.sv
// Parametrised multi-read-port register file with write-to-read bypass and a
// per-register busy scoreboard used by decode to stall on unwritten operands.
module regfile_sb #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned NRD      = 2,
   parameter int unsigned BYPASS   = 1,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     wa,
   input  logic [DATA_W-1:0]     wd,
   input  logic [NRD*ADDR_W-1:0] ra,
   output logic [NRD*DATA_W-1:0] rd,
   output logic [NRD-1:0]        rd_busy,
   input  logic                  rsv_en,
   input  logic [ADDR_W-1:0]     rsv_addr,
   output logic                  rsv_err,
   output logic [ADDR_W:0]       busy_cnt
);

   localparam int unsigned NREG  = 2 ** ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam bit          ZR    = (ZERO_REG != 0);
   localparam bit          BP    = (BYPASS != 0);

   logic [DATA_W-1:0] rf [NREG];
   logic [NREG-1:0]   busy;
   logic [NREG-1:0]   busy_nxt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              rsv_err_nxt;
   logic              wr_ok;

   assign wr_ok = we && !(ZR && (wa == '0));

   // Register storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else if (wr_ok) begin
         rf[wa] <= wd;
      end
   end

   // Scoreboard next state: a new reservation outranks a same-cycle writeback
   always_comb begin
      busy_nxt = busy;
      cnt_nxt  = '0;
      for (int r = 0; r < NREG; r++) begin
         if (rsv_en && (rsv_addr == ADDR_W'(r)) && !(ZR && (r == 0)))
            busy_nxt[r] = 1'b1;
         else if (we && (wa == ADDR_W'(r)))
            busy_nxt[r] = 1'b0;
      end
      for (int r = 0; r < NREG; r++) cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[r]);
      rsv_err_nxt = rsv_en && busy[rsv_addr] && !(we && (wa == rsv_addr))
                    && !(ZR && (rsv_addr == '0));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= '0;
         busy_cnt <= '0;
         rsv_err  <= 1'b0;
      end else begin
         busy     <= busy_nxt;
         busy_cnt <= cnt_nxt;
         rsv_err  <= rsv_err_nxt;
      end
   end

   // Independent combinational read ports
   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic              zero;
      logic              fwd;
      assign a    = ra[i*ADDR_W +: ADDR_W];
      assign zero = ZR && (a == '0);
      assign fwd  = BP && we && (wa == a);
      assign rd[i*DATA_W +: DATA_W] = zero ? '0 : (fwd ? wd : rf[a]);
      assign rd_busy[i] = !zero && busy[a] && !fwd;
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb; a second instance with the
// bypass disabled shares all inputs to cover the non-forwarding read path.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic [9:0]  ra;
   logic [63:0] rd, rd_nb;
   logic [1:0]  rd_busy, rd_busy_nb;
   logic        rsv_en;
   logic [4:0]  rsv_addr;
   logic        rsv_err, rsv_err_nb;
   logic [5:0]  busy_cnt, busy_cnt_nb;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_sb #(.BYPASS(1)) dut (
      .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd),
      .rd_busy(rd_busy), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .rsv_err(rsv_err), .busy_cnt(busy_cnt)
   );

   regfile_sb #(.BYPASS(0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_nb),
      .rd_busy(rd_busy_nb), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .rsv_err(rsv_err_nb), .busy_cnt(busy_cnt_nb)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra = '0;
      rsv_en = 1'b0; rsv_addr = '0;
      #2;
      check("reset_rd", rd, 64'h0);
      check("reset_busy", 64'(rd_busy), 64'h0);
      check("reset_cnt", 64'(busy_cnt), 64'h0);
      check("reset_err", 64'(rsv_err), 64'h0);
      #10 rst_n = 1'b1;

      // reset mid-operation
      we = 1'b1; wa = 5'd5; wd = 32'h1234; ra = {5'd7, 5'd5};
      tick();
      we = 1'b0; rsv_en = 1'b1; rsv_addr = 5'd7;
      tick();
      rsv_en = 1'b0;
      #1;
      check("r5_written", 64'(rd[31:0]), 64'h1234);
      check("r7_busy", 64'(rd_busy), 64'h2);
      check("cnt_one", 64'(busy_cnt), 64'h1);
      rst_n = 1'b0;
      #1;
      check("async_rd", rd, 64'h0);
      check("async_busy", 64'(rd_busy), 64'h0);
      check("async_cnt", 64'(busy_cnt), 64'h0);
      rst_n = 1'b1;
      tick();
      check("post_reset_r5", 64'(rd[31:0]), 64'h0);

      // zero register ignores writes and reservations
      we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; rsv_en = 1'b1; rsv_addr = 5'd0;
      ra = {5'd0, 5'd0};
      #1;
      check("zero_rd_comb", rd, 64'h0);
      check("zero_busy_comb", 64'(rd_busy), 64'h0);
      tick();
      we = 1'b0; rsv_en = 1'b0;
      #1;
      check("zero_rd", rd, 64'h0);
      check("zero_cnt", 64'(busy_cnt), 64'h0);
      check("zero_err", 64'(rsv_err), 64'h0);

      // bypass vs stored value
      we = 1'b1; wa = 5'd3; wd = 32'h11;
      tick();
      wd = 32'h22; ra = {5'd3, 5'd3};
      #1;
      check("byp_rd", rd, {32'h22, 32'h22});
      check("nobyp_rd_pre", rd_nb, {32'h11, 32'h11});
      tick();
      we = 1'b0;
      #1;
      check("nobyp_rd_post", rd_nb, {32'h22, 32'h22});
      check("byp_rd_post", 64'(rd[31:0]), 64'h22);

      // scoreboard stall and release
      rsv_en = 1'b1; rsv_addr = 5'd9;
      tick();
      rsv_en = 1'b0; ra = {5'd3, 5'd9};
      #1;
      check("stall_busy", 64'(rd_busy), 64'h1);
      check("stall_cnt", 64'(busy_cnt), 64'h1);
      we = 1'b1; wa = 5'd9; wd = 32'hABCD;
      #1;
      check("wb_busy_byp", 64'(rd_busy), 64'h0);
      check("wb_rd_byp", 64'(rd[31:0]), 64'hABCD);
      check("wb_busy_nobyp", 64'(rd_busy_nb), 64'h1);
      tick();
      we = 1'b0;
      #1;
      check("wb_cnt", 64'(busy_cnt), 64'h0);
      check("wb_busy_nobyp_post", 64'(rd_busy_nb), 64'h0);
      check("wb_rd_nobyp_post", 64'(rd_nb[31:0]), 64'hABCD);

      // simultaneous reserve and writeback of a busy register
      rsv_en = 1'b1; rsv_addr = 5'd12;
      tick();
      we = 1'b1; wa = 5'd12; wd = 32'h5A5A;
      tick();
      we = 1'b0; rsv_en = 1'b0; ra = {5'd3, 5'd12};
      #1;
      check("simul_cnt", 64'(busy_cnt), 64'h1);
      check("simul_err", 64'(rsv_err), 64'h0);
      check("simul_busy", 64'(rd_busy), 64'h1);
      check("simul_rd", 64'(rd[31:0]), 64'h5A5A);
      we = 1'b1; wa = 5'd12;
      tick();
      we = 1'b0;
      #1;
      check("simul_clear_cnt", 64'(busy_cnt), 64'h0);

      // double reservation pulses rsv_err for one cycle
      rsv_en = 1'b1; rsv_addr = 5'd4;
      tick();
      check("rsv4_err", 64'(rsv_err), 64'h0);
      tick();
      rsv_en = 1'b0;
      check("dbl_err", 64'(rsv_err), 64'h1);
      check("dbl_cnt", 64'(busy_cnt), 64'h1);
      tick();
      check("dbl_err_clear", 64'(rsv_err), 64'h0);

      // fill r1..r31
      for (int i = 1; i < 32; i++) begin
         rsv_en = 1'b1; rsv_addr = 5'(i);
         tick();
      end
      rsv_en = 1'b0;
      #1;
      check("full_cnt", 64'(busy_cnt), 64'd31);
      check("full_cnt_nb", 64'(busy_cnt_nb), 64'd31);
      rsv_en = 1'b1; rsv_addr = 5'd0;
      tick();
      rsv_en = 1'b0;
      check("full_r0_cnt", 64'(busy_cnt), 64'd31);
      check("full_r0_err", 64'(rsv_err), 64'h0);
      we = 1'b1; wa = 5'd31; wd = 32'h77;
      tick();
      we = 1'b0;
      check("full_wb_cnt", 64'(busy_cnt), 64'd30);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-read-port register file for the multicycle/pipelined processor core.
- Generalises the 32x32, 2-read-port file:
  - configurable width, depth and read-port count
  - asynchronous clear of all registers
  - optional write-to-read bypass
  - per-register busy scoreboard that lets control logic stall on operands whose producer has not yet written back
- Sits between decode (read addresses, reservations) and writeback (write port).

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register address width; depth NREG = 2**ADDR_W.
- NRD, 2, number of combinational read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = reads return stored value only.
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and reservations.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- we  in  1  write enable (writeback).
- wa  in  ADDR_W  write address.
- wd  in  DATA_W  write data.
- ra  in  NRD*ADDR_W  read addresses, port i in bits [i*ADDR_W +: ADDR_W].
- rd  out  NRD*DATA_W  read data, port i in bits [i*DATA_W +: DATA_W].
- rd_busy  out  NRD  port i operand has an outstanding reservation (stall request).
- rsv_en  in  1  reserve destination register at issue.
- rsv_addr  in  ADDR_W  register to reserve.
- rsv_err  out  1  registered pulse: reservation hit an already-busy register.
- busy_cnt  out  ADDR_W+1  number of currently busy registers.

Behaviour:
- Storage: NREG x DATA_W array (rf) plus NREG-bit busy vector.
- Reset (rst_n low, asynchronous assert, released synchronously to clk by the top level):
  - every rf entry = 0, busy = 0, rsv_err = 0, busy_cnt = 0
  - hence rd = 0 and rd_busy = 0 for all ports while in reset
  - a write or reserve in flight when reset asserts is lost.
- Write: on posedge clk with we=1, rf[wa] <= wd.
  - If ZERO_REG=1 and wa=0, the write is ignored.
- Read, combinational per port i:
  - if ZERO_REG=1 and ra_i=0 -> rd_i = 0
  - else if BYPASS=1 and we=1 and wa=ra_i -> rd_i = wd
  - else rd_i = rf[ra_i].
  - Zero-latency, no clock involved.
- Scoreboard, on posedge clk, evaluated per register r:
  - set = rsv_en and rsv_addr=r (masked for r=0 when ZERO_REG=1)
  - clr = we and wa=r
  - busy[r] <= set ? 1 : (clr ? 0 : busy[r])
  - Same-cycle reserve and writeback of the same register: reserve wins, busy stays 1 (a new producer has been issued).
  - A writeback to a non-busy register is legal and leaves busy at 0.
- rd_busy_i, combinational:
  - busy[ra_i] and not (BYPASS=1 and we=1 and wa=ra_i), forced 0 for ra_i=0 when ZERO_REG=1.
  - With BYPASS=0, a same-cycle writeback does not clear rd_busy_i until the next cycle.
- rsv_err <= rsv_en and busy[rsv_addr] and not (we and wa=rsv_addr) and not (ZERO_REG and rsv_addr=0).
  - One-cycle pulse, diagnostic only.
  - Busy stays 1 in that case; the double reservation is not counted twice.
- busy_cnt: registered population count of the busy vector, updated the same edge as busy. Maximum NREG-1 with ZERO_REG=1, NREG otherwise.
- Multiple read ports may address the same register; each port resolves independently.
- No simulation $display in synthesisable paths.

Test Plan:
- Reset mid-operation: write r5=0x1234, reserve r7, then pulse rst_n low for 1 ns between edges -> immediately rd (ra=5) = 0, rd_busy = 0, busy_cnt = 0; after release, r5 reads 0.
- Zero register: we=1, wa=0, wd=0xFFFFFFFF; rsv_en=1, rsv_addr=0 -> ra=0 reads 0, rd_busy=0, busy_cnt stays 0, rsv_err=0.
- Bypass: rf[3]=0x11; same cycle we=1, wa=3, wd=0x22, ra0=3, ra1=3 -> BYPASS=1: rd0=rd1=0x22 before the edge. BYPASS=0: 0x11 before the edge, 0x22 after.
- Scoreboard stall: reserve r9, then ra0=9 -> rd_busy[0]=1, busy_cnt=1; writeback wa=9, wd=0xABCD -> BYPASS=1: rd_busy[0]=0 and rd0=0xABCD in the same cycle; busy_cnt=0 after the edge.
- Simultaneous reserve and writeback of r12 (r12 busy) -> after the edge busy[12]=1, busy_cnt unchanged, rsv_err=0, rf[12]=wd.
- Double reservation of busy r4 with no writeback -> rsv_err=1 for exactly one cycle, busy_cnt unchanged. Then fill r1..r31 reservations -> busy_cnt=31.
